// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with mid-bit sampling, false-start
// rejection, framing-error and overrun reporting, and a one-entry
// valid/ready output buffer.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | line idle, waiting for rxs to fall
// ST_START   | half-bit wait, then confirm start bit is still low
// ST_DATA    | sampling 8 data bits, LSB first, one per bit period
// ST_STOP    | sampling the stop bit
// ST_WAIT_HI | bad stop bit seen; wait for the line to return high

module uart_rx_frontend #(
  parameter int PRESCALER   = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] O_DATA,
  output logic       O_VALID,
  input  logic       I_READY,
  output logic       O_FRAME_ERR,
  output logic       O_OVERRUN,
  output logic       O_BUSY
);

  localparam int CW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CW-1:0] FULL_LD = CW'(PRESCALER - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(PRESCALER / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   tick;
  logic                   good_stop;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign tick      = (cnt == '0);
  assign good_stop = (state == ST_STOP) && tick && rxs;

  // Synchronise the asynchronous line; reset to the idle (high) level.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
    end
  end

  // Receive FSM, shift register and one-entry output buffer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      O_DATA      <= '0;
      O_VALID     <= 1'b0;
      O_FRAME_ERR <= 1'b0;
      O_OVERRUN   <= 1'b0;
      O_BUSY      <= 1'b0;
    end else begin
      O_FRAME_ERR <= 1'b0;
      O_OVERRUN   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            cnt    <= HALF_LD;
            state  <= ST_START;
            O_BUSY <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rxs) begin
              state  <= ST_IDLE;
              O_BUSY <= 1'b0;
            end else begin
              cnt     <= FULL_LD;
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= FULL_LD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rxs) begin
              state  <= ST_IDLE;
              O_BUSY <= 1'b0;
            end else begin
              O_FRAME_ERR <= 1'b1;
              state       <= ST_WAIT_HI;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (rxs) begin
            state  <= ST_IDLE;
            O_BUSY <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          O_BUSY <= 1'b0;
        end
      endcase

      // A completing frame may reuse the slot being handed off this cycle.
      if (good_stop) begin
        if (!O_VALID || I_READY) begin
          O_DATA  <= shreg;
          O_VALID <= 1'b1;
        end else begin
          O_OVERRUN <= 1'b1;
        end
      end else if (O_VALID && I_READY) begin
        O_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Testbench for uart_rx_frontend: scoreboard of expected bytes fed by the
// stimulus, checked by an independent monitor on each handshake.

module tb_uart_rx_frontend;

  localparam int P  = 8;
  localparam int SS = 2;
  localparam int LAT = SS + P / 2 + 9 * P + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       UART_RX = 1'b1;
  logic       I_READY = 1'b0;
  logic [7:0] O_DATA;
  logic       O_VALID;
  logic       O_FRAME_ERR;
  logic       O_OVERRUN;
  logic       O_BUSY;

  uart_rx_frontend #(.PRESCALER(P), .SYNC_STAGES(SS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .UART_RX    (UART_RX),
    .O_DATA     (O_DATA),
    .O_VALID    (O_VALID),
    .I_READY    (I_READY),
    .O_FRAME_ERR(O_FRAME_ERR),
    .O_OVERRUN  (O_OVERRUN),
    .O_BUSY     (O_BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int exp_ferr = 0, obs_ferr = 0;
  int exp_ovr  = 0, obs_ovr  = 0;
  int rise_cyc = -1, ovr_cyc = -1;
  int valid_cycles = 0;
  bit busy_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one frame; line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    UART_RX = 1'b0;
    tick_n(P);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      tick_n(P);
    end
    UART_RX = stop;
    tick_n(P);
  endtask

  // Monitor: pops the scoreboard on each handshake, tallies pulses.
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (O_VALID && !prev_valid) rise_cyc = cyc;
        if (O_VALID) valid_cycles++;
        if (O_BUSY) busy_seen = 1'b1;
        if (O_FRAME_ERR) obs_ferr++;
        if (O_OVERRUN) begin
          obs_ovr++;
          ovr_cyc = cyc;
        end
        if (prev_valid && O_VALID && !prev_hs)
          check("data_hold", int'(O_DATA), int'(prev_data));
        if (O_VALID && I_READY) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte actual=0x%0h required=none", O_DATA);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", int'(O_DATA), int'(e));
          end
        end
      end
      prev_valid = O_VALID;
      prev_hs    = O_VALID && I_READY;
      prev_data  = O_DATA;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, lat, c22, n;
    logic [7:0] d;

    // Reset hold with a toggling line
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      UART_RX = ~UART_RX;
      @(negedge CLK);
      check("reset_outputs", int'({O_VALID, O_BUSY, O_FRAME_ERR, O_OVERRUN, O_DATA}), 0);
      @(posedge CLK);
      #1;
    end
    UART_RX = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("post_reset_outputs", int'({O_VALID, O_BUSY, O_FRAME_ERR, O_OVERRUN, O_DATA}), 0);
    tick_n(4);

    // Two bytes with one idle bit between, consumer always ready
    I_READY = 1'b1;
    v0 = valid_cycles;
    exp_q.push_back(8'h55);
    lat = cyc;
    send_frame(8'h55, 1'b1);
    check_range("latency", rise_cyc - lat, LAT - 1, LAT + 1);
    tick_n(P);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    tick_n(4);
    check("valid_cycles_2b", valid_cycles - v0, 2);
    check("sb_empty_2b", exp_q.size(), 0);
    check("ferr_2b", obs_ferr, exp_ferr);
    check("ovr_2b", obs_ovr, exp_ovr);

    // False start
    busy_seen = 1'b0;
    v0 = valid_cycles;
    UART_RX = 1'b0;
    tick_n(3);
    UART_RX = 1'b1;
    tick_n(6);
    @(negedge CLK);
    check("false_start_busy_seen", int'(busy_seen), 1);
    check("false_start_busy_end", int'(O_BUSY), 0);
    check("false_start_no_valid", valid_cycles - v0, 0);
    check("false_start_ferr", obs_ferr, exp_ferr);
    tick_n(4);

    // Framing error, long low, then a good frame
    send_frame(8'h3C, 1'b0);
    exp_ferr++;
    tick_n(40);
    UART_RX = 1'b1;
    tick_n(16);
    check("ferr_once", obs_ferr, exp_ferr);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick_n(4);
    check("sb_empty_ferr", exp_q.size(), 0);
    check("ferr_after_good", obs_ferr, exp_ferr);

    // Overrun with consumer stalled
    I_READY = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick_n(P);
    c22 = cyc;
    send_frame(8'h22, 1'b1);
    exp_ovr++;
    tick_n(2);
    @(negedge CLK);
    check("ovr_count", obs_ovr, exp_ovr);
    check("ovr_timing", ovr_cyc - c22, LAT);
    check("ovr_keep_data", int'(O_DATA), 8'h11);
    check("ovr_keep_valid", int'(O_VALID), 1);
    @(posedge CLK);
    #1;
    I_READY = 1'b1;
    tick_n(1);
    I_READY = 1'b0;
    @(negedge CLK);
    check("ovr_valid_drop", int'(O_VALID), 0);
    check("sb_empty_ovr", exp_q.size(), 0);
    tick_n(4);

    // Handshake on the same cycle a new frame completes
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick_n(P);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick_n(LAT - 1);
        I_READY = 1'b1;
        tick_n(1);
        I_READY = 1'b0;
        @(negedge CLK);
        check("simul_valid", int'(O_VALID), 1);
        check("simul_data", int'(O_DATA), 8'h22);
      end
    join
    tick_n(2);
    check("simul_no_ovr", obs_ovr, exp_ovr);
    I_READY = 1'b1;
    tick_n(2);
    check("sb_empty_simul", exp_q.size(), 0);

    // Reset during data bit 4
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick_n(P * 5 + 2);
        RST = 1'b0;
        tick_n(1);
        RST = 1'b1;
        @(negedge CLK);
        check("midreset_busy", int'(O_BUSY), 0);
        check("midreset_valid", int'(O_VALID), 0);
      end
    join
    tick_n(P);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick_n(4);
    check("sb_empty_midreset", exp_q.size(), 0);

    // Randomised mix of good frames, false starts and bad stop bits
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(0, 9);
      d = 8'($urandom);
      if (n == 0) begin
        UART_RX = 1'b0;
        tick_n($urandom_range(1, 3));
        UART_RX = 1'b1;
        tick_n(12);
      end else if (n == 1) begin
        send_frame(d, 1'b0);
        exp_ferr++;
        tick_n($urandom_range(0, 20));
        UART_RX = 1'b1;
        tick_n(4);
      end else begin
        exp_q.push_back(d);
        send_frame(d, 1'b1);
        tick_n($urandom_range(0, 10));
      end
    end
    tick_n(10);
    check("sb_empty_rand", exp_q.size(), 0);
    check("ferr_rand", obs_ferr, exp_ferr);
    check("ovr_rand", obs_ovr, exp_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
